// File: rtl/major_state_seq_pkg.sv
// Shared definitions for the major-state sequencer.
//  - 4-bit state codes: Fetch 0-3, Defer 4-7, Execute 8-11, Halt 12-15.
//    state[3:2] is the major state and state[1:0] is the phase.
//  - Opcode values for instruction[0:2], the {op,ind} patterns for JMP, and the HLT mask.
package major_state_seq_pkg;

   typedef enum logic [3:0] {
      ST_F0 = 4'd0,  ST_F1 = 4'd1,  ST_F2 = 4'd2,  ST_F3 = 4'd3,
      ST_D0 = 4'd4,  ST_D1 = 4'd5,  ST_D2 = 4'd6,  ST_D3 = 4'd7,
      ST_E0 = 4'd8,  ST_E1 = 4'd9,  ST_E2 = 4'd10, ST_E3 = 4'd11,
      ST_H0 = 4'd12, ST_H1 = 4'd13, ST_H2 = 4'd14, ST_H3 = 4'd15
   } state_e;

   typedef enum logic [1:0] {
      MAJ_F = 2'd0, MAJ_D = 2'd1, MAJ_E = 2'd2, MAJ_H = 2'd3
   } major_e;

   // Where a major state goes after its phase 3.
   typedef enum logic [1:0] {
      NXT_DEFER = 2'd0, NXT_EXEC = 2'd1, NXT_BOUND = 2'd2
   } next_e;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_TAD = 3'd1;
   localparam logic [2:0] OP_ISZ = 3'd2;
   localparam logic [2:0] OP_DCA = 3'd3;
   localparam logic [2:0] OP_JMS = 3'd4;
   localparam logic [2:0] OP_JMP = 3'd5;
   localparam logic [2:0] OP_IOT = 3'd6;
   localparam logic [2:0] OP_OPR = 3'd7;

   // {op, ind}
   localparam logic [3:0] JMPD = 4'b1010;
   localparam logic [3:0] JMPI = 4'b1011;

   // Group-2 OPR with HLT: op 7, bit3=1, bit10=1, bit11=0.
   localparam logic [0:11] HLT_MASK  = 12'o7403;
   localparam logic [0:11] HLT_MATCH = 12'o7402;

endpackage

// File: rtl/major_state_seq_next_major_dec.sv
// next_major_dec: pure combinational decode of the instruction register.
//  major       in   2   current major state (F/D/E/H)
//  instruction in   12  [0:11] IR contents, bit 0 is the MSB
//  nxt         out  2   destination after phase 3: defer, execute or boundary
//  is_hlt      out  1   instruction is a HLT-class operate
// Only meaningful while the sequencer sits in phase 3.
module next_major_dec
   import major_state_seq_pkg::*;
(
   input  logic [1:0]  major,
   input  logic [0:11] instruction,
   output next_e       nxt,
   output logic        is_hlt
);

   logic [2:0] op;
   logic       ind;

   assign op     = instruction[0:2];
   assign ind    = instruction[3];
   assign is_hlt = (instruction & HLT_MASK) == HLT_MATCH;

   always_comb begin
      nxt = NXT_BOUND;
      case (major)
         MAJ_F: begin
            // Direct JMP completes in fetch; IOT/OPR never touch memory again.
            if ({op, ind} == JMPD)       nxt = NXT_BOUND;
            else if (ind && op <= OP_JMP) nxt = NXT_DEFER;
            else if (!ind && op <= OP_JMS) nxt = NXT_EXEC;
            else                          nxt = NXT_BOUND;
         end
         MAJ_D:   nxt = ({op, ind} == JMPI) ? NXT_BOUND : NXT_EXEC;
         default: nxt = NXT_BOUND;
      endcase
   end

endmodule

// File: rtl/major_state_seq.sv
// major_state_seq: major-state / phase sequencer for the PC, MA, AC and memory blocks.
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  instruction  in   12  [0:11] IR contents, valid from F3 onward
//  mem_busy     in   1   stalls phase 1 of F/D/E
//  halt_sw      in   1   front-panel HALT (level)
//  cont_sw      in   1   front-panel CONT (one-clk pulse)
//  step_sw      in   1   front-panel SINGLE STEP (one-clk pulse)
//  int_req      in   1   OR of device interrupt flags
//  ion          in   1   interrupt enable
//  state        out  4   current major state/phase code
//  run          out  1   not halted
//  instr_done   out  1   high in the cycle an instruction boundary is taken
//  int_ack      out  1   high through F0..F3 of a forced interrupt fetch
module major_state_seq
   import major_state_seq_pkg::*;
#(
   parameter bit HALT_ON_RESET = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [0:11] instruction,
   input  logic        mem_busy,
   input  logic        halt_sw,
   input  logic        cont_sw,
   input  logic        step_sw,
   input  logic        int_req,
   input  logic        ion,
   output logic [3:0]  state,
   output logic        run,
   output logic        instr_done,
   output logic        int_ack
);

   localparam state_e RST_STATE = HALT_ON_RESET ? ST_H0 : ST_F0;

   state_e state_q, state_d;
   logic   run_q, run_d;
   logic   hlt_pend_q, hlt_pend_d;
   logic   step_pend_q, step_pend_d;
   logic   int_ack_q, int_ack_d;
   logic   done_c;

   logic [1:0] major;
   logic [1:0] phase;
   next_e      nxt;
   logic       is_hlt;

   assign major = state_q[3:2];
   assign phase = state_q[1:0];

   next_major_dec u_dec (
      .major       (major),
      .instruction (instruction),
      .nxt         (nxt),
      .is_hlt      (is_hlt)
   );

   always_comb begin
      state_d     = state_q;
      hlt_pend_d  = hlt_pend_q;
      step_pend_d = step_pend_q;
      int_ack_d   = int_ack_q;
      done_c      = 1'b0;

      if (major == MAJ_H) begin
         // H0..H2 run through unconditionally; panel pulses only matter in H3.
         if (phase != 2'd3) begin
            state_d = state_e'(state_q + 4'd1);
         end else if (!halt_sw) begin
            if (cont_sw) begin
               state_d = ST_F0;
            end else if (step_sw) begin
               state_d     = ST_F0;
               step_pend_d = 1'b1;
            end
         end
      end else if (phase == 2'd1 && mem_busy) begin
         state_d = state_q;
      end else if (phase != 2'd3) begin
         state_d = state_e'(state_q + 4'd1);
      end else begin
         if (major == MAJ_F) begin
            int_ack_d = 1'b0;
            if (is_hlt) hlt_pend_d = 1'b1;
         end
         case (nxt)
            NXT_DEFER: state_d = ST_D0;
            NXT_EXEC:  state_d = ST_E0;
            default: begin
               done_c = 1'b1;
               // hlt_pend_d so a HLT decoded in this very F3 halts at once.
               if (halt_sw || hlt_pend_d || step_pend_q) begin
                  state_d     = ST_H0;
                  hlt_pend_d  = 1'b0;
                  step_pend_d = 1'b0;
               end else begin
                  state_d   = ST_F0;
                  int_ack_d = int_req & ion;
               end
            end
         endcase
      end

      run_d = (state_d[3:2] != MAJ_H);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RST_STATE;
         run_q       <= !HALT_ON_RESET;
         hlt_pend_q  <= 1'b0;
         step_pend_q <= 1'b0;
         int_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         hlt_pend_q  <= hlt_pend_d;
         step_pend_q <= step_pend_d;
         int_ack_q   <= int_ack_d;
      end
   end

   assign state      = state_q;
   assign run        = run_q;
   assign instr_done = done_c;
   assign int_ack    = int_ack_q;

endmodule

// File: tb/tb_major_state_seq.sv
// Bench for major_state_seq: a major/phase reference model compared every cycle,
// plus directed sequences with literal expected state codes.
module tb_major_state_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] ir = 12'o1200;
   logic        mem_busy = 1'b0, halt_sw = 1'b0, cont_sw = 1'b0, step_sw = 1'b0;
   logic        int_req = 1'b0, ion = 1'b0;
   logic [3:0]  state;
   logic        run, instr_done, int_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   major_state_seq #(.HALT_ON_RESET(1'b0)) dut (
      .clk(clk), .reset(reset), .instruction(ir), .mem_busy(mem_busy),
      .halt_sw(halt_sw), .cont_sw(cont_sw), .step_sw(step_sw),
      .int_req(int_req), .ion(ion), .state(state), .run(run),
      .instr_done(instr_done), .int_ack(int_ack)
   );

   task automatic chk4(input string nm, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model (major 0=F 1=D 2=E 3=H, phase 0..3) ----------
   int m_maj = 0, m_ph = 0;
   bit m_hltp = 0, m_stepp = 0, m_ack = 0;

   // 0 = defer, 1 = execute, 2 = instruction boundary
   function automatic int dest(input int maj, input logic [11:0] i);
      int op;
      op = int'(i[11:9]);
      if (maj == 0) begin
         if (i[8] && op <= 5)  return 0;
         if (!i[8] && op <= 4) return 1;
         return 2;
      end
      if (maj == 1) return (op == 5) ? 2 : 1;
      return 2;
   endfunction

   function automatic bit hlt_op(input logic [11:0] i);
      return i[11:9] == 3'o7 && i[8] && i[1] && !i[0];
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_maj <= 0; m_ph <= 0; m_hltp <= 0; m_stepp <= 0; m_ack <= 0;
      end else if (m_maj == 3) begin
         if (m_ph < 3) m_ph <= m_ph + 1;
         else if (!halt_sw && (cont_sw || step_sw)) begin
            m_maj <= 0; m_ph <= 0; m_stepp <= !cont_sw;
         end
      end else if (m_ph == 1 && mem_busy) begin
         m_ph <= m_ph;
      end else if (m_ph < 3) begin
         m_ph <= m_ph + 1;
      end else begin
         if (m_maj == 0) m_ack <= 0;
         if (dest(m_maj, ir) == 0) begin
            m_maj <= 1; m_ph <= 0; m_hltp <= m_hltp || (m_maj == 0 && hlt_op(ir));
         end else if (dest(m_maj, ir) == 1) begin
            m_maj <= 2; m_ph <= 0; m_hltp <= m_hltp || (m_maj == 0 && hlt_op(ir));
         end else if (halt_sw || m_stepp || m_hltp || (m_maj == 0 && hlt_op(ir))) begin
            m_maj <= 3; m_ph <= 0; m_hltp <= 0; m_stepp <= 0;
         end else begin
            m_maj <= 0; m_ph <= 0; m_ack <= int_req && ion;
         end
      end
   end

   // Compare on the falling edge, well away from the rising edge and input changes.
   always @(negedge clk) begin
      chk4("model_state", state, 4'(m_maj * 4 + m_ph));
      chk1("model_run", run, m_maj != 3);
      chk1("model_done", instr_done, reset && m_maj != 3 && m_ph == 3 && dest(m_maj, ir) == 2);
      chk1("model_int_ack", int_ack, m_ack);
   end

   // ---------------- directed sequences ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic step_exp(input string nm, input logic [3:0] exp_st, input logic exp_done);
      chk4(nm, state, exp_st);
      chk1({nm, "_done"}, instr_done, exp_done);
      tick();
   endtask

   logic [3:0] tad_s [8]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};
   logic [3:0] jmp_s [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6, 4'd7};
   logic [3:0] hlt_s [8]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd12, 4'd13, 4'd14, 4'd15};
   logic [3:0] cla_s [5]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd12};
   logic [3:0] hsw_s [9]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};

   initial begin
      #1 reset = 1'b0;
      tick();
      chk4("reset_state", state, 4'd0);
      chk1("reset_run", run, 1'b1);
      chk1("reset_done", instr_done, 1'b0);
      chk1("reset_int_ack", int_ack, 1'b0);
      reset = 1'b1;

      // TAD direct: F0..F3, E0..E3, back to F0 after 8 clocks
      for (int i = 0; i < 8; i++) step_exp("tad", tad_s[i], i == 7);
      chk4("tad_end", state, 4'd0);

      // JMP I with mem_busy held 3 clocks in D1; no execute cycle
      ir = 12'o5420;
      for (int i = 0; i < 11; i++) begin
         mem_busy = (i >= 5 && i <= 7);
         step_exp("jmpi", jmp_s[i], i == 10);
      end
      mem_busy = 1'b0;
      chk4("jmpi_end", state, 4'd0);

      // HLT: mem_busy in F2/H2 ignored, panel pulses in H0/H1 ignored
      ir = 12'o7402;
      for (int i = 0; i < 8; i++) begin
         mem_busy = (i == 2 || i == 6);
         step_sw  = (i == 4);
         cont_sw  = (i == 5);
         step_exp("hlt", hlt_s[i], i == 3);
      end
      mem_busy = 1'b0; step_sw = 1'b0; cont_sw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk4("hlt_hold", state, 4'd15);
         chk1("hlt_run", run, 1'b0);
         tick();
      end

      // single step twice through CLA, each halts again exactly once
      for (int n = 0; n < 2; n++) begin
         step_sw = 1'b1; tick(); step_sw = 1'b0;
         ir = 12'o7200;
         chk1("step_run", run, 1'b1);
         for (int i = 0; i < 5; i++) step_exp("step", cla_s[i], i == 3);
         tick(); tick();
         chk4("step_h3", state, 4'd15);
      end
      repeat (5) tick();
      chk4("step_stays", state, 4'd15);

      // cont and step together: cont wins, CLA runs without halting
      cont_sw = 1'b1; step_sw = 1'b1; tick(); cont_sw = 1'b0; step_sw = 1'b0;
      chk4("cont_f0", state, 4'd0);
      chk1("cont_run", run, 1'b1);
      for (int i = 0; i < 4; i++) step_exp("cont", 4'(i), i == 3);
      chk4("cont_end", state, 4'd0);

      // interrupt requested during ISZ E1
      ir = 12'o2100; ion = 1'b1;
      for (int i = 0; i < 8; i++) begin
         int_req = (i >= 5);
         step_exp("isz", tad_s[i], i == 7);
      end
      int_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk1("intf_ack", int_ack, 1'b1);
         step_exp("intf", 4'(i), 1'b0);
      end
      chk4("intf_e0", state, 4'd8);
      chk1("intf_ack_clr", int_ack, 1'b0);

      // async reset during E2
      tick(); tick();
      chk4("pre_rst_e2", state, 4'd10);
      reset = 1'b0;
      #1;
      chk4("async_rst", state, 4'd0);
      tick();
      reset = 1'b1;

      // halt_sw at E1: instruction completes, halts after E3
      ir = 12'o1200;
      for (int i = 0; i < 9; i++) begin
         if (i == 5) halt_sw = 1'b1;
         step_exp("hsw", hsw_s[i], i == 7);
      end
      repeat (5) tick();
      chk4("hsw_hold", state, 4'd15);

      // interrupt while halted: no effect until a boundary after resuming
      halt_sw = 1'b0; int_req = 1'b1; ion = 1'b1;
      tick(); tick();
      chk4("hint_h3", state, 4'd15);
      cont_sw = 1'b1; tick(); cont_sw = 1'b0;
      chk4("hint_f0", state, 4'd0);
      chk1("hint_ack0", int_ack, 1'b0);
      for (int i = 0; i < 8; i++) step_exp("hint", tad_s[i], i == 7);
      chk1("hint_ack1", int_ack, 1'b1);
      int_req = 1'b0;

      // JMP direct ends in fetch
      ir = 12'o5020;
      for (int i = 0; i < 4; i++) step_exp("jmpd", 4'(i), i == 3);
      chk4("jmpd_end", state, 4'd0);
      chk1("jmpd_ack", int_ack, 1'b0);

      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
